// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-road intersection controller. Sequences the north-south and east-west
//   heads through green, yellow and all-red clearance on a prescaled time base.
//   A latched pedestrian request shortens the running green and stretches the
//   next all-red into a walk interval. Night mode substitutes a flashing
//   pattern (ns yellow / ew red), entered and left only through all-red.
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active low
//   ped_req        : pedestrian button (level or single-cycle pulse)
//   night_mode     : flashing-operation request
//   ns_green/yellow/red, ew_green/yellow/red : signal heads (registered)
//   walk           : pedestrian walk lamp (registered)
//   cnt            : ticks left in the current phase, 0 = last tick
module traffic_light_ctrl #(
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 1,
  parameter int GREEN_T   = 9,
  parameter int YELLOW_T  = 2,
  parameter int RED_CLR_T = 1,
  parameter int WALK_T    = 6,
  parameter int PED_SHORT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ped_req,
  input  logic             night_mode,
  output logic             ns_green,
  output logic             ns_yellow,
  output logic             ns_red,
  output logic             ew_green,
  output logic             ew_yellow,
  output logic             ew_red,
  output logic             walk,
  output logic [CNT_W-1:0] cnt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_NSG   = 3'd0;
  localparam logic [2:0] S_NSY   = 3'd1;
  localparam logic [2:0] S_AR1   = 3'd2;
  localparam logic [2:0] S_EWG   = 3'd3;
  localparam logic [2:0] S_EWY   = 3'd4;
  localparam logic [2:0] S_AR2   = 3'd5;
  localparam logic [2:0] S_FLASH = 3'd6;

  localparam logic [CNT_W-1:0] C_GREEN = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] C_YEL   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_RED   = CNT_W'(RED_CLR_T - 1);
  localparam logic [CNT_W-1:0] C_WALK  = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(PED_SHORT);

  // lamp vector order: {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red}
  localparam logic [5:0] L_ALLRED = 6'b001_001;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_q, walk_d;
  logic             flash_q, flash_d;
  logic [5:0]       lamp_q, lamp_d;
  logic             tick, is_green;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign is_green = (state_q == S_NSG) || (state_q == S_EWG);

  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    walk_d     = walk_q;
    flash_d    = flash_q;
    ped_pend_d = ped_pend_q | ped_req;

    if (tick) begin
      if (state_q == S_FLASH) begin
        if (!night_mode) begin
          state_d = S_AR2;
          cnt_d   = C_RED;
          flash_d = 1'b0;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (cnt_q != '0) begin
        // A request seen this very cycle already counts, so a one-cycle
        // pulse trims the green at the tick that samples it.
        if (is_green && (ped_pend_q || ped_req) && (cnt_q > C_SHORT))
          cnt_d = C_SHORT;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unique case (state_q)
          S_NSG: begin state_d = S_NSY; cnt_d = C_YEL; end
          S_EWG: begin state_d = S_EWY; cnt_d = C_YEL; end
          S_NSY, S_EWY: begin
            // Walk takes the request pending before this cycle; a press in
            // this cycle waits for the next crossing.
            state_d    = (state_q == S_NSY) ? S_AR1 : S_AR2;
            walk_d     = ped_pend_q;
            ped_pend_d = ped_req;
            cnt_d      = ped_pend_q ? C_WALK : C_RED;
          end
          default: begin
            walk_d = 1'b0;
            if (night_mode) begin
              state_d = S_FLASH;
              cnt_d   = '0;
              flash_d = 1'b1;
            end else begin
              state_d = (state_q == S_AR1) ? S_EWG : S_NSG;
              cnt_d   = C_GREEN;
            end
          end
        endcase
      end
    end

    if (state_d == S_FLASH) ped_pend_d = 1'b0;

    // Lamps are decoded from the next state so they are registered outputs.
    unique case (state_d)
      S_NSG:   lamp_d = 6'b100_001;
      S_NSY:   lamp_d = 6'b010_001;
      S_EWG:   lamp_d = 6'b001_100;
      S_EWY:   lamp_d = 6'b001_010;
      S_FLASH: lamp_d = {1'b0, flash_d, 3'b000, flash_d};
      default: lamp_d = L_ALLRED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_AR2;
      cnt_q      <= C_RED;
      presc_q    <= '0;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      flash_q    <= 1'b0;
      lamp_q     <= L_ALLRED;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      flash_q    <= flash_d;
      lamp_q     <= lamp_d;
    end
  end

  assign {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red} = lamp_q;
  assign walk = walk_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;
  localparam int CNT_W = 4;
  localparam int G = 9, Y = 2, RC = 1, WK = 6, PS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ped_req, night_mode;
  logic ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk;
  logic [CNT_W-1:0] cnt;

  traffic_light_ctrl #(.CNT_W(CNT_W), .TICK_DIV(1), .GREEN_T(G), .YELLOW_T(Y),
    .RED_CLR_T(RC), .WALK_T(WK), .PED_SHORT(PS)) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .night_mode(night_mode),
    .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
    .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
    .walk(walk), .cnt(cnt));

  // Second instance with a divided time base, free running.
  logic r4, p4, n4;
  logic g4, y4, rd4, eg4, ey4, er4, w4;
  logic [CNT_W-1:0] c4;
  traffic_light_ctrl #(.CNT_W(CNT_W), .TICK_DIV(4)) u4 (
    .clk(clk), .reset(r4), .ped_req(p4), .night_mode(n4),
    .ns_green(g4), .ns_yellow(y4), .ns_red(rd4),
    .ew_green(eg4), .ew_yellow(ey4), .ew_red(er4),
    .walk(w4), .cnt(c4));

  int n_pass = 0, n_tot = 0;
  bit done4 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phases 0..5 = NS green, NS yellow, all-red 1, EW green, EW yellow,
  // all-red 2; 6 = flashing. m_rem = ticks remaining in the phase.
  int m_ph, m_rem;
  bit m_pend, m_walk, m_fph, mvalid = 0;

  function automatic logic [5:0] exp_lamps(input int ph, input bit fph);
    logic [5:0] tab [6];
    tab = '{6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};
    if (ph == 6) return {1'b0, fph, 3'b000, fph};
    return tab[ph];
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_ph = 5; m_rem = RC - 1; m_pend = 0; m_walk = 0; m_fph = 0;
    end else if (m_ph == 6) begin
      if (!night_mode) begin m_ph = 5; m_rem = RC - 1; m_fph = 0; end
      else m_fph = !m_fph;
    end else if (m_rem > 0) begin
      if ((m_ph % 3 == 0) && (m_pend || ped_req) && m_rem > PS) m_rem = PS;
      else m_rem = m_rem - 1;
      m_pend = m_pend | ped_req;
    end else if (m_ph % 3 == 1) begin
      m_walk = m_pend; m_pend = ped_req; m_ph = m_ph + 1;
      m_rem = (m_walk ? WK : RC) - 1;
    end else if (m_ph % 3 == 2) begin
      m_walk = 0;
      if (night_mode) begin m_ph = 6; m_rem = 0; m_fph = 1; m_pend = 0; end
      else begin m_ph = (m_ph + 1) % 6; m_rem = G - 1; m_pend = m_pend | ped_req; end
    end else begin
      m_ph = m_ph + 1; m_rem = Y - 1; m_pend = m_pend | ped_req;
    end
    mvalid = 1;
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("model_lamps", int'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red}),
          int'(exp_lamps(m_ph, m_fph)));
      chk("model_cnt", int'(cnt), m_rem);
      chk("model_walk", int'(walk), int'(m_walk));
      chk("no_conflict", int'((ns_green | ns_yellow) & (ew_green | ew_yellow)), 0);
    end
  end

  // ---------------- prescaled instance ----------------
  initial begin
    logic [CNT_W+5:0] prev, cur;
    int run, last_rise;
    bit prev_g;
    r4 = 0; p4 = 0; n4 = 0;
    repeat (2) @(negedge clk);
    r4 = 1;
    for (int i = 0; i < 50 && !g4; i++) @(negedge clk);
    chk("u4_start", int'(g4), 1);
    prev = {g4, y4, rd4, eg4, ey4, er4, c4};
    run = 1; last_rise = 0; prev_g = 1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      cur = {g4, y4, rd4, eg4, ey4, er4, c4};
      if (cur != prev) begin chk("u4_hold", run, 4); run = 1; prev = cur; end
      else run++;
      if (g4 && !prev_g) begin chk("u4_period", c - last_rise, 96); last_rise = c; end
      prev_g = g4;
    end
    done4 = 1;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int ng, ne, nr;
    reset = 0; ped_req = 0; night_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_ns_red", int'(ns_red), 1);
    chk("rst_ew_red", int'(ew_red), 1);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_walk", int'(walk), 0);
    reset = 1;
    @(negedge clk);
    chk("first_nsg", int'(ns_green), 1);
    chk("first_cnt", int'(cnt), 8);

    // free run: one full 24-cycle period
    ng = 0; ne = 0; nr = 0;
    for (int i = 0; i < 24; i++) begin
      ng += int'(ns_green); ne += int'(ew_green); nr += int'(ns_red & ew_red);
      @(negedge clk);
    end
    chk("run_nsg_len", ng, 9);
    chk("run_ewg_len", ne, 9);
    chk("run_allred_len", nr, 2);
    chk("run_wrap_nsg", int'(ns_green), 1);
    chk("run_wrap_cnt", int'(cnt), 8);

    // pedestrian shortening
    for (int i = 0; i < 60 && !(ns_green && cnt == 7); i++) @(negedge clk);
    chk("wait_ped", int'(ns_green && cnt == 7), 1);
    ped_req = 1;
    @(negedge clk); ped_req = 0;
    chk("ped_short_cnt", int'(cnt), 3);
    repeat (4) @(negedge clk);
    chk("ped_yellow", int'(ns_yellow), 1);
    chk("ped_yellow_cnt", int'(cnt), 1);
    repeat (2) @(negedge clk);
    chk("ped_walk_on", int'(walk), 1);
    chk("ped_walk_cnt", int'(cnt), 5);
    repeat (5) @(negedge clk);
    chk("ped_walk_last", int'(walk && cnt == 0 && ns_red && ew_red), 1);
    @(negedge clk);
    chk("ped_walk_off", int'(walk), 0);
    chk("ped_ewg", int'(ew_green && cnt == 8), 1);

    // request on the yellow exit cycle
    for (int i = 0; i < 60 && !(ns_yellow && cnt == 0); i++) @(negedge clk);
    chk("wait_bnd", int'(ns_yellow && cnt == 0), 1);
    ped_req = 1;
    @(negedge clk);
    chk("bnd_no_walk", int'(walk), 0);
    chk("bnd_ar1_cnt", int'(cnt), 0);
    @(negedge clk); ped_req = 0;
    chk("bnd_ewg", int'(ew_green && cnt == 8), 1);
    @(negedge clk);
    chk("bnd_ew_short", int'(cnt), 3);
    for (int i = 0; i < 60 && !(ew_yellow && cnt == 0); i++) @(negedge clk);
    @(negedge clk);
    chk("bnd_ar2_walk", int'(walk), 1);
    chk("bnd_ar2_cnt", int'(cnt), 5);

    // night mode
    for (int i = 0; i < 60 && !ew_green; i++) @(negedge clk);
    night_mode = 1;
    for (int i = 0; i < 60 && !ns_yellow; i++) @(negedge clk);
    chk("fl_ns_y", int'(ns_yellow), 1);
    chk("fl_ew_r", int'(ew_red), 1);
    chk("fl_ns_r", int'(ns_red), 0);
    chk("fl_cnt", int'(cnt), 0);
    @(negedge clk);
    chk("fl_off", int'(ns_yellow | ew_red), 0);
    ped_req = 1;
    @(negedge clk); ped_req = 0;
    chk("fl_on2", int'(ns_yellow & ew_red), 1);
    night_mode = 0;
    @(negedge clk);
    chk("fl_exit_ar2", int'(ns_red && ew_red && cnt == 0 && !walk), 1);
    @(negedge clk);
    chk("fl_resume", int'(ns_green && cnt == 8), 1);
    @(negedge clk);
    chk("fl_req_ignored", int'(cnt), 7);

    // reset during a walk
    ped_req = 1;
    @(negedge clk); ped_req = 0;
    for (int i = 0; i < 60 && !(walk && cnt == 3); i++) @(negedge clk);
    chk("wait_rw", int'(walk && cnt == 3), 1);
    reset = 0;
    @(negedge clk);
    chk("rw_red", int'(ns_red && ew_red && !ns_green && !ew_green), 1);
    chk("rw_walk", int'(walk), 0);
    chk("rw_cnt", int'(cnt), 0);
    reset = 1;
    @(negedge clk);
    chk("rw_nsg", int'(ns_green && cnt == 8), 1);
    @(negedge clk);
    chk("rw_no_pend", int'(cnt), 7);
    repeat (30) @(negedge clk);

    for (int i = 0; i < 400 && !done4; i++) @(negedge clk);
    chk("u4_done", int'(done4), 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-road intersection controller; the next generation of the single-road traffic light block. It sequences north-south and east-west signal heads through green, yellow and all-red clearance phases, with configurable phase lengths and a prescaled time base. It adds a latched pedestrian request that shortens the running green and inserts a walk interval, and a night flashing mode. It sits between the board clock/reset and the LED/7-segment drivers; `cnt` feeds the countdown display.

## Interface
- `CNT_W`, 4: width of `cnt`; must hold max(GREEN_T, WALK_T) − 1.
- `TICK_DIV`, 1: clock cycles per time tick; ≥ 1 (1 = tick every cycle, used for simulation).
- `GREEN_T`, 9: green length in ticks; ≥ 2.
- `YELLOW_T`, 2: yellow length in ticks; ≥ 1.
- `RED_CLR_T`, 1: all-red clearance length in ticks; ≥ 1.
- `WALK_T`, 6: all-red length in ticks when a walk is served; ≥ RED_CLR_T.
- `PED_SHORT`, 3: remaining green count forced by a pending request; < GREEN_T.
- `clk` input, 1: the single clock; everything is clocked on its rising edge.
- `reset` input, 1: synchronous, active-low.
- `ped_req` input, 1: pedestrian button, level or pulse, sampled every cycle.
- `night_mode` input, 1: request for flashing operation.
- `ns_green`, `ns_yellow`, `ns_red` output, 1 each: north-south head.
- `ew_green`, `ew_yellow`, `ew_red` output, 1 each: east-west head.
- `walk` output, 1: pedestrian walk lamp.
- `cnt` output, CNT_W: ticks remaining in the current phase (0 = last tick).

## Operation
- All outputs are registered and are a function of state only (Moore). Exactly one lamp per head is on, except in FLASH.
- Prescaler: counts 0..TICK_DIV−1 and wraps. `tick` = 1 in the cycle the prescaler equals TICK_DIV−1. State, `cnt` and `flash_ph` change only on tick cycles.
- States and lamps:
  - NS_GREEN: ns_green, ew_red.
  - NS_YELLOW: ns_yellow, ew_red.
  - ALL_RED_1: both red.
  - EW_GREEN: ew_green, ns_red.
  - EW_YELLOW: ew_yellow, ns_red.
  - ALL_RED_2: both red.
  - FLASH: ns_yellow = ew_red = flash_ph; all other lamps 0.
- On a tick with `cnt` > 0: `cnt` decrements. Exception: in a green state with ped_pend = 1 and `cnt` > PED_SHORT, `cnt` is loaded with PED_SHORT.
- On a tick with `cnt` = 0, the state advances and `cnt` loads (phase length − 1):
  - NS_GREEN → NS_YELLOW → ALL_RED_1 → EW_GREEN → EW_YELLOW → ALL_RED_2 → NS_GREEN.
- Pedestrian handling:
  - ped_pend is set in any cycle with `ped_req` = 1 (outside FLASH).
  - On a yellow → all-red transition, the `walk` register loads ped_pend and ped_pend loads `ped_req`. A request in that same cycle stays queued for the next crossing.
  - The all-red length is WALK_T if `walk` = 1, otherwise RED_CLR_T.
  - `walk` clears when the all-red state is left.
- Night mode:
  - `night_mode` is sampled only on the exit tick of ALL_RED_1/ALL_RED_2. If it is 1, the next state is FLASH, with `cnt` = 0 and flash_ph = 1.
  - In FLASH, flash_ph toggles every tick, `cnt` holds 0, ped_pend is held at 0 and `walk` is 0.
  - On a FLASH tick with `night_mode` = 0, the next state is ALL_RED_2 with `cnt` = RED_CLR_T − 1. Service resumes via NS_GREEN.

## Timing
- Reset (`reset` = 0 at a rising edge) values:
  - state = ALL_RED_2.
  - ns_red = ew_red = 1; all other lamps 0; walk = 0.
  - cnt = RED_CLR_T − 1; prescaler = 0; ped_pend = 0; flash_ph = 0.
- A reset mid-phase, including in FLASH or during a walk, returns to these values on the next edge. Any pending request is discarded.
- Outputs change one cycle after the tick cycle that causes the change.
- With defaults and TICK_DIV = 1:
  - The first cycle after reset release is ALL_RED_2, `cnt` = 0.
  - NS_GREEN lasts 9 cycles (`cnt` 8..0), NS_YELLOW 2, ALL_RED_1 1, EW_GREEN 9, EW_YELLOW 2, ALL_RED_2 1.
  - Cycle period is 24.
- `ped_req` is captured in the cycle it is high; a one-cycle pulse suffices. Its effect on `cnt` appears at the next tick.

## Test plan
- Free run, defaults: release reset, then observe the 24-cycle sequence. `cnt` reads 8,7,…,0 in each green; the two heads are never green/yellow at the same time.
- Pedestrian shortening: pulse `ped_req` while NS_GREEN `cnt` = 7 → next cycle `cnt` = 3, then 2,1,0; yellow for 2 cycles; ALL_RED_1 for 6 cycles with `walk` = 1, `cnt` 5..0; `walk` = 0 at EW_GREEN.
- Request at the boundary: `ped_req` = 1 in the NS_YELLOW `cnt` = 0 cycle → served in the following ALL_RED_2, not ALL_RED_1; with `ped_req` also high in ALL_RED_1, ped_pend remains 1 afterwards.
- Night mode: assert `night_mode` during EW_GREEN → FLASH is entered only after ALL_RED_2. `ns_yellow`/`ew_red` then alternate 1,0,1,… per tick. Deassert → ALL_RED_2 for 1 cycle, then NS_GREEN with `cnt` = 8.
- Prescaler: with TICK_DIV = 4, every `cnt` value is held for exactly 4 cycles; a full cycle is 96 clocks.
- Reset mid-operation: hold `reset` low during a walk in ALL_RED_1 with `cnt` = 3 → next edge gives both heads red, `walk` = 0, `cnt` = 0, and no pending walk afterwards.
